// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the fp issue stages.
package fp_pkg;

   localparam int unsigned EXP_DEFAULT   = 8;
   localparam int unsigned MANT_DEFAULT  = 23;
   localparam int unsigned WIDTH_DEFAULT = 1 + EXP_DEFAULT + MANT_DEFAULT;

   localparam logic [WIDTH_DEFAULT-1:0] QNAN =
      {1'b0, {EXP_DEFAULT{1'b1}}, 1'b1, {(MANT_DEFAULT-1){1'b0}}};

   typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

   typedef enum logic [0:0] {StIdle, StWait} issue_state_t;

   // Works on pre-reduced field flags so it stays independent of EXP/MANT.
   // Denormals fall into FP_ZERO (flush-to-zero).
   function automatic fp_class_t fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic mant_zero);
      if (exp_zero) begin
         return FP_ZERO;
      end else if (exp_ones) begin
         return mant_zero ? FP_INF : FP_NAN;
      end
      return FP_NORM;
   endfunction

   function automatic logic [WIDTH_DEFAULT-1:0] fp_inf(input logic sign);
      return {sign, {EXP_DEFAULT{1'b1}}, {MANT_DEFAULT{1'b0}}};
   endfunction

   function automatic logic [WIDTH_DEFAULT-1:0] fp_zero(input logic sign);
      return {sign, {(EXP_DEFAULT+MANT_DEFAULT){1'b0}}};
   endfunction

endpackage

// File: rtl/fp_div_special.sv
// Combinational IEEE special-case resolver for a/b; flags pairs the divider need not see.
module fp_div_special
   import fp_pkg::*;
#(
   parameter int unsigned EXP  = EXP_DEFAULT,
   parameter int unsigned MANT = MANT_DEFAULT
) (
   input  logic [EXP+MANT:0] a_i,
   input  logic [EXP+MANT:0] b_i,
   output logic              is_special_o,
   output logic [EXP+MANT:0] special_result_o
);

   localparam int unsigned WIDTH = 1 + EXP + MANT;

   fp_class_t  cls_a;
   fp_class_t  cls_b;
   logic       sign;

   assign cls_a = fp_classify(a_i[WIDTH-2:MANT] == '0, &a_i[WIDTH-2:MANT],
                              a_i[MANT-1:0] == '0);
   assign cls_b = fp_classify(b_i[WIDTH-2:MANT] == '0, &b_i[WIDTH-2:MANT],
                              b_i[MANT-1:0] == '0);
   assign sign  = a_i[WIDTH-1] ^ b_i[WIDTH-1];

   // Priority: NaN-producing cases, then infinities, then zeros.
   always_comb begin
      is_special_o     = 1'b1;
      special_result_o = '0;
      if (cls_a == FP_NAN || cls_b == FP_NAN ||
          (cls_a == FP_ZERO && cls_b == FP_ZERO) ||
          (cls_a == FP_INF && cls_b == FP_INF)) begin
         special_result_o = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
      end else if (cls_b == FP_ZERO || cls_a == FP_INF) begin
         special_result_o = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
      end else if (cls_a == FP_ZERO || cls_b == FP_INF) begin
         special_result_o = {sign, {(EXP+MANT){1'b0}}};
      end else begin
         is_special_o = 1'b0;
      end
   end

endmodule

// File: rtl/fp_div_issue.sv
// Issue stage in front of the shared iterative fp_div: operand FIFO, local special-case
// resolution and strictly in-order result delivery.
module fp_div_issue
   import fp_pkg::*;
#(
   parameter int unsigned EXP   = EXP_DEFAULT,
   parameter int unsigned MANT  = MANT_DEFAULT,
   parameter int unsigned WIDTH = 1 + EXP + MANT,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             clock_sreset,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   input  logic             data_valid,
   output logic             in_ready,
   output logic             overflow,
   output logic [WIDTH-1:0] div_dataa,
   output logic [WIDTH-1:0] div_datab,
   output logic             div_data_valid,
   input  logic             div_result_valid,
   input  logic [WIDTH-1:0] div_result,
   output logic             result_valid,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop, fifo_empty;
   logic [WIDTH-1:0]   head_a, head_b;
   logic               head_special;
   logic [WIDTH-1:0]   head_special_result;

   issue_state_t       state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               result_valid_q, result_valid_d;
   logic [WIDTH-1:0]   div_dataa_q, div_dataa_d;
   logic [WIDTH-1:0]   div_datab_q, div_datab_d;
   logic               div_data_valid_q, div_data_valid_d;
   logic               overflow_q, overflow_d;

   assign in_ready   = (count_q != CNT_W'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = data_valid & in_ready;
   assign {head_a, head_b} = mem_q[rd_ptr_q];

   fp_div_special #(
      .EXP  (EXP),
      .MANT (MANT)
   ) u_special (
      .a_i              (head_a),
      .b_i              (head_b),
      .is_special_o     (head_special),
      .special_result_o (head_special_result)
   );

   // FIFO storage; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {dataa, datab};
      end
   end

   // FIFO pointer/count next state.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; heads are only inspected (and popped) in StIdle.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (!head_special) begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (div_result_valid) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // FSM outputs: next values for the registered result/divider interface.
   always_comb begin
      result_d         = result_q;
      result_valid_d   = 1'b0;
      div_dataa_d      = div_dataa_q;
      div_datab_d      = div_datab_q;
      div_data_valid_d = 1'b0;
      overflow_d       = overflow_q | (data_valid & ~in_ready);
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               if (head_special) begin
                  result_d       = head_special_result;
                  result_valid_d = 1'b1;
               end else begin
                  div_dataa_d      = head_a;
                  div_datab_d      = head_b;
                  div_data_valid_d = 1'b1;
               end
            end
         end
         StWait: begin
            if (div_result_valid) begin
               result_d       = div_result;
               result_valid_d = 1'b1;
            end
         end
      endcase
   end

   // Datapath and FIFO control registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         result_q         <= '0;
         result_valid_q   <= 1'b0;
         div_dataa_q      <= '0;
         div_datab_q      <= '0;
         div_data_valid_q <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         result_q         <= result_d;
         result_valid_q   <= result_valid_d;
         div_dataa_q      <= div_dataa_d;
         div_datab_q      <= div_datab_d;
         div_data_valid_q <= div_data_valid_d;
         overflow_q       <= overflow_d;
      end
   end

   assign result         = result_q;
   assign result_valid   = result_valid_q;
   assign div_dataa      = div_dataa_q;
   assign div_datab      = div_datab_q;
   assign div_data_valid = div_data_valid_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_fp_div_issue.sv
// Bench for fp_div_issue with a behavioural fp_div stand-in and an in-order scoreboard.
module tb_fp_div_issue;

   localparam int C_ZERO = 0;
   localparam int C_NORM = 1;
   localparam int C_INF  = 2;
   localparam int C_NAN  = 3;

   typedef struct {
      logic [31:0] val;
      int          ecyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   logic        clock;
   logic        clock_sreset;
   logic [31:0] dataa, datab;
   logic        data_valid;
   logic        in_ready, overflow;
   logic [31:0] div_dataa, div_datab;
   logic        div_data_valid;
   logic        div_result_valid;
   logic [31:0] div_result;
   logic        result_valid;
   logic [31:0] result;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_issue = 0;
   int   n_res = 0;
   int   last_issue_cyc = 0;
   int   dropped = 0;
   int   div_lat = 2;
   int   cyc = 0;
   bit   busy = 0;
   bit   genuine_prev = 0;
   bit   spurious_req = 0;
   exp_t exp_q[$];
   vec_t tbl[11];

   fp_div_issue #(
      .EXP   (8),
      .MANT  (23),
      .WIDTH (32),
      .DEPTH (4)
   ) dut (
      .clock            (clock),
      .clock_sreset     (clock_sreset),
      .dataa            (dataa),
      .datab            (datab),
      .data_valid       (data_valid),
      .in_ready         (in_ready),
      .overflow         (overflow),
      .div_dataa        (div_dataa),
      .div_datab        (div_datab),
      .div_data_valid   (div_data_valid),
      .div_result_valid (div_result_valid),
      .div_result       (div_result),
      .result_valid     (result_valid),
      .result           (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int cls(input logic [31:0] x);
      if (x[30:23] == 8'h00) return C_ZERO;
      if (x[30:23] == 8'hFF) return (x[22:0] == 23'h0) ? C_INF : C_NAN;
      return C_NORM;
   endfunction

   function automatic real to_real(input logic [31:0] x);
      logic [10:0] ed;
      ed = 11'(int'(x[30:23]) + 896);
      return $bitstoreal({x[31], ed, x[22:0], 29'h0});
   endfunction

   // Quotient of two normals, truncated back to single precision.
   function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] d;
      int          e;
      d = $realtobits(to_real(a) / to_real(b));
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int   ca, cb;
      s  = a[31] ^ b[31];
      ca = cls(a);
      cb = cls(b);
      if (ca == C_NAN || cb == C_NAN) return 32'h7FC0_0000;
      if (ca == cb && (ca == C_ZERO || ca == C_INF)) return 32'h7FC0_0000;
      if (cb == C_ZERO || ca == C_INF) return {s, 8'hFF, 23'h0};
      if (ca == C_ZERO || cb == C_INF) return {s, 31'h0};
      return ref_quot(a, b);
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       return {r[31], 31'h0};
         1:       return {r[31], 8'h00, r[22:0] | 23'h1};
         2:       return {r[31], 8'hFF, 23'h0};
         3:       return {r[31], 8'hFF, r[22:0] | 23'h1};
         default: return {r[31], 8'($urandom_range(64, 190)), r[22:0]};
      endcase
   endfunction

   // Call at a negedge; leaves data_valid high and returns at the next negedge.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input bit timed);
      exp_t e;
      dataa      = a;
      datab      = b;
      data_valid = 1'b1;
      if (in_ready) begin
         e.val  = r;
         e.ecyc = timed ? cyc + 2 : -1;
         exp_q.push_back(e);
      end else begin
         dropped++;
      end
      @(negedge clock);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy || div_data_valid) && t < 400) begin
         @(negedge clock);
         t++;
      end
      chk({name, "_outstanding"}, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clock);
   endtask

   task automatic do_reset();
      clock_sreset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      clock_sreset = 1'b0;
   endtask

   // fp_div stand-in plus output monitor, both evaluated once per negedge.
   initial begin : model_mon
      logic [31:0] q;
      int          cnt;
      bit          rst_s;
      bit          ddv_prev;
      exp_t        e;
      div_result_valid = 1'b0;
      div_result       = 32'h0;
      q        = 32'h0;
      cnt      = 0;
      ddv_prev = 1'b0;
      forever begin
         @(posedge clock);
         rst_s = clock_sreset;
         @(negedge clock);
         if (rst_s) begin
            busy         = 1'b0;
            genuine_prev = 1'b0;
         end
         if (genuine_prev) chk("result_after_div_result", 32'(result_valid), 32'd1);
         if (result_valid) begin
            n_res++;
            if (exp_q.size() == 0) begin
               chk("unexpected_result_valid", 32'(result_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e.val);
               if (e.ecyc >= 0) chk("result_cycle", 32'(cyc), 32'(e.ecyc));
            end
         end
         if (div_data_valid) begin
            n_issue++;
            last_issue_cyc = cyc;
            chk("div_data_valid_single", 32'(ddv_prev), 32'd0);
         end
         ddv_prev = div_data_valid;

         genuine_prev     = 1'b0;
         div_result_valid = 1'b0;
         if (busy) begin
            if (cnt == 0) begin
               div_result_valid = 1'b1;
               div_result       = q;
               genuine_prev     = 1'b1;
               busy             = 1'b0;
            end else begin
               cnt--;
            end
         end else if (spurious_req) begin
            div_result_valid = 1'b1;
            div_result       = 32'h1234_5678;
            spurious_req     = 1'b0;
         end
         if (div_data_valid && !rst_s) begin
            busy = 1'b1;
            q    = ref_quot(div_dataa, div_datab);
            cnt  = div_lat;
         end
      end
   end

   initial begin : main
      int          i0, r0, d0, t, k;
      logic [31:0] a, b;
      tbl[0]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
      tbl[1]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000};
      tbl[2]  = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000};
      tbl[3]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000};
      tbl[4]  = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000};
      tbl[5]  = '{32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000};
      tbl[6]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000};
      tbl[7]  = '{32'h0000_0000, 32'hFF80_0000, 32'h8000_0000};
      tbl[8]  = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000};
      tbl[9]  = '{32'hBF80_0000, 32'h8000_0000, 32'h7F80_0000};
      tbl[10] = '{32'h3F80_0000, 32'h807F_FFFF, 32'hFF80_0000};

      clock_sreset = 1'b1;
      data_valid   = 1'b0;
      dataa        = 32'h0;
      datab        = 32'h0;
      repeat (3) @(negedge clock);
      clock_sreset = 1'b0;

      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_div_data_valid", 32'(div_data_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'h0);
      chk("rst_div_dataa", div_dataa, 32'h0);
      chk("rst_div_datab", div_datab, 32'h0);

      // Back-to-back specials: each due exactly two cycles after its push.
      i0 = n_issue;
      for (int i = 0; i < 11; i++) drive(tbl[i].a, tbl[i].b, tbl[i].r, 1'b1);
      data_valid = 1'b0;
      drain("specials");
      chk("specials_no_issue", 32'(n_issue - i0), 32'd0);

      // 1.0 / 2.0 through the divider.
      div_lat = 3;
      i0 = n_issue;
      k  = cyc;
      drive(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0);
      data_valid = 1'b0;
      drain("half");
      chk("half_one_issue", 32'(n_issue - i0), 32'd1);
      chk("half_issue_cycle", 32'(last_issue_cyc), 32'(k + 2));
      chk("half_result_held", result, 32'h3F00_0000);
      chk("half_div_dataa_held", div_dataa, 32'h3F80_0000);
      chk("half_div_datab_held", div_datab, 32'h4000_0000);

      // -6.0 / 3.0: one pulse only.
      div_lat = 0;
      r0 = n_res;
      drive(32'hC0C0_0000, 32'h4040_0000, 32'hC000_0000, 1'b0);
      data_valid = 1'b0;
      drain("neg6div3");
      chk("neg6div3_one_pulse", 32'(n_res - r0), 32'd1);

      // Special waits behind an outstanding divide.
      div_lat = 4;
      drive(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
      drive(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0);
      data_valid = 1'b0;
      drain("ordering");

      // Spurious div_result_valid while idle must be ignored.
      r0 = n_res;
      spurious_req = 1'b1;
      repeat (5) @(negedge clock);
      chk("spurious_no_result", 32'(n_res - r0), 32'd0);
      chk("spurious_result_held", result, 32'h7F80_0000);

      // Fill the FIFO while the divider is busy: the sixth push is dropped.
      div_lat = 10;
      d0 = dropped;
      for (int i = 0; i < 6; i++) begin
         a = {1'b0, 8'(127 + i), 23'h0};
         drive(a, 32'h3F80_0000, a, 1'b0);
      end
      chk("full_dropped", 32'(dropped - d0), 32'd1);
      chk("full_overflow", 32'(overflow), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      data_valid = 1'b0;
      drain("full");
      chk("overflow_sticky", 32'(overflow), 32'd1);

      // Randomised mix against the reference model.
      for (int i = 0; i < 80; i++) begin
         a = rand_operand();
         b = rand_operand();
         div_lat = $urandom_range(0, 5);
         drive(a, b, ref_result(a, b), 1'b0);
         if ($urandom_range(0, 2) == 0) begin
            data_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clock);
         end
      end
      data_valid = 1'b0;
      drain("random");

      // Reset while waiting on the divider.
      div_lat = 10;
      i0 = n_issue;
      drive(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0);
      data_valid = 1'b0;
      t = 0;
      while (n_issue == i0 && t < 20) begin
         @(negedge clock);
         t++;
      end
      chk("wait_entered", 32'(n_issue - i0), 32'd1);
      do_reset();
      chk("wrst_in_ready", 32'(in_ready), 32'd1);
      chk("wrst_result_valid", 32'(result_valid), 32'd0);
      chk("wrst_div_data_valid", 32'(div_data_valid), 32'd0);
      chk("wrst_overflow", 32'(overflow), 32'd0);
      r0 = n_res;
      repeat (15) @(negedge clock);
      chk("wrst_no_stale_result", 32'(n_res - r0), 32'd0);
      div_lat = 2;
      drive(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b0);
      data_valid = 1'b0;
      drain("after_reset");
      chk("after_reset_result", result, 32'h3F00_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
